// File: rtl/sub3_serial.sv
// sub3_serial: digit-serial three-operand subtractor, c = (y - a - b) mod 2^N.
// Processes one 2-bit digit per clock, least significant digit first. The
// final borrow becomes the underflow flag. Operands enter and the result
// leaves through valid/ready handshakes. Only one operation is in flight.
module sub3_serial #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] y,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         under
);

    localparam int DIGITS = (N + 1) / 2;
    localparam int W      = 2 * DIGITS;
    localparam int CW     = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  y_sh;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  res;
    logic [1:0]    borrow;
    logic [CW-1:0] cnt;
    logic [N-1:0]  c_reg;
    logic          under_reg;

    logic [3:0]    t;
    logic [1:0]    r;
    logic [1:0]    borrow_next;
    logic [W+1:0]  res_cat;
    logic [W-1:0]  res_next;

    // Handshake outputs depend on state only, so there is no path from in_valid or out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign c         = c_reg;
    assign under     = under_reg;

    // Digit slice: t = diff + 12 lies in 4..15. Adding 12, a multiple of 4, keeps
    // r = t mod 4 equal to diff mod 4, and the borrow out is 3 - floor(t/4), in 0..2.
    // NOTE: combinational logic uses blocking assignments. Every output is
    // assigned on every pass, so no latch can be inferred.
    always_comb begin
        t           = 4'd12 + {2'b00, y_sh[1:0]} - {2'b00, a_sh[1:0]}
                            - {2'b00, b_sh[1:0]} - {2'b00, borrow};
        r           = t[1:0];
        borrow_next = 2'd3 - t[3:2];
        res_cat     = {r, res};
        res_next    = res_cat[W+1:2];
    end

    // Control FSM with operand, result and flag registers. Reset clears every register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            y_sh      <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            borrow    <= '0;
            cnt       <= '0;
            c_reg     <= '0;
            under_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        y_sh   <= W'(y);
                        a_sh   <= W'(a);
                        b_sh   <= W'(b);
                        res    <= '0;
                        borrow <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    y_sh   <= y_sh >> 2;
                    a_sh   <= a_sh >> 2;
                    b_sh   <= b_sh >> 2;
                    res    <= res_next;
                    borrow <= borrow_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(DIGITS - 1)) begin
                        // The padding bit above N is dropped. A non-negative result always fits in N bits.
                        c_reg     <= res_next[N-1:0];
                        under_reg <= (borrow_next != 2'd0);
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
